// File: rtl/tb_pkg.sv
// rtl/tb_pkg.sv - shared codes and state encoding for the TB port-B read path
package tb_pkg;

  // Direction codes carried in sel[1:0]
  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_POS  = 2'b01;
  localparam logic [1:0] DIR_NEG  = 2'b10;
  localparam logic [1:0] DIR_NEW  = 2'b11;

  // Destination codes carried in sel[2]
  localparam logic TB_B       = 1'b0;
  localparam logic TB_B_cache = 1'b1;

  // All-idle select code, shared by both destinations
  localparam logic [2:0] SEL_IDLE = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

  // Select code presented to the remap stage alongside a TB word
  function automatic logic [2:0] make_sel(input logic dst, input logic [1:0] dir);
    return {dst, dir};
  endfunction

endpackage

// File: rtl/tb_sel_delay.sv
// rtl/tb_sel_delay.sv - RD_LAT-deep delay line for sel code and last-row flag
module tb_sel_delay #(
  parameter int RD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] sel_i,
  input  logic       last_i,
  input  logic       done_i,
  output logic [2:0] sel_o,
  output logic       last_o
);

  logic [RD_LAT-1:0][2:0] sel_q, sel_d;
  logic [RD_LAT-1:0]      last_q, last_d;

  // Shift one stage per cycle; done_i lands directly in the output stage so an
  // empty command can report completion without waiting out the read latency
  always_comb begin
    sel_d     = sel_q;
    last_d    = last_q;
    sel_d[0]  = sel_i;
    last_d[0] = last_i;
    for (int i = 1; i < RD_LAT; i++) begin
      sel_d[i]  = sel_q[i-1];
      last_d[i] = last_q[i-1];
    end
    last_d[RD_LAT-1] = last_d[RD_LAT-1] | done_i;
  end

  // Pipeline registers, cleared on reset so an aborted command leaves nothing in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q  <= '0;
      last_q <= '0;
    end else begin
      sel_q  <= sel_d;
      last_q <= last_d;
    end
  end

  assign sel_o  = sel_q[RD_LAT-1];
  assign last_o = last_q[RD_LAT-1];

endmodule

// File: rtl/tb_portb_rd_seq.sv
// rtl/tb_portb_rd_seq.sv - TB port-B row read sequencer with latency-aligned sel code
module tb_portb_rd_seq
  import tb_pkg::*;
#(
  parameter int TB_AW  = 10,
  parameter int LEN_W  = 8,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             sys_rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [TB_AW-1:0] cmd_base,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [TB_AW-1:0] cmd_stride,
  input  logic             cmd_dst,
  input  logic [1:0]       cmd_dir,
  input  logic             rd_stall,
  output logic             TB_enb,
  output logic [TB_AW-1:0] TB_addrb,
  output logic [2:0]       TB_doutb_sel,
  output logic             busy,
  output logic             rd_done
);

  rd_state_e        state_q, state_d;
  logic [TB_AW-1:0] addr_q, addr_d;
  logic [TB_AW-1:0] stride_q, stride_d;
  logic [TB_AW-1:0] addrb_q, addrb_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] k_q, k_d;
  logic             dst_q, dst_d;
  logic [1:0]       dir_q, dir_d;
  logic             zlen_q, zlen_d;
  logic             enb_q, enb_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;

  logic [2:0]       pipe_sel_in;
  logic             pipe_last_in;
  logic             pipe_done_in;
  logic             pipe_last_out;

  // Next-state: accept in IDLE, issue one row per unstalled cycle, then wait
  // in DRAIN until the last row's code has reached the remap stage
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    stride_d = stride_q;
    addrb_d  = addrb_q;
    len_d    = len_q;
    k_d      = k_q;
    dst_d    = dst_q;
    dir_d    = dir_q;
    zlen_d   = zlen_q;
    enb_d    = 1'b0;
    last_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d   = cmd_base;
          stride_d = cmd_stride;
          len_d    = cmd_len;
          dst_d    = cmd_dst;
          dir_d    = cmd_dir;
          k_d      = '0;
          zlen_d   = (cmd_len == '0);
          state_d  = (cmd_len == '0) ? ST_DRAIN : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!rd_stall) begin
          enb_d   = 1'b1;
          addrb_d = addr_q;
          addr_d  = addr_q + stride_q;
          k_d     = k_q + 1'b1;
          if (k_q == len_q - LEN_W'(1)) begin
            last_d  = 1'b1;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        zlen_d = 1'b0;
        if (pipe_last_out) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Single register bank for FSM state, command context and registered outputs
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      stride_q <= '0;
      addrb_q  <= '0;
      len_q    <= '0;
      k_q      <= '0;
      dst_q    <= 1'b0;
      dir_q    <= 2'b00;
      zlen_q   <= 1'b0;
      enb_q    <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      stride_q <= stride_d;
      addrb_q  <= addrb_d;
      len_q    <= len_d;
      k_q      <= k_d;
      dst_q    <= dst_d;
      dir_q    <= dir_d;
      zlen_q   <= zlen_d;
      enb_q    <= enb_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
    end
  end

  // The code enters the delay line the cycle TB_enb is high, so it emerges
  // RD_LAT cycles later together with the BRAM word
  always_comb begin
    pipe_sel_in  = enb_q ? make_sel(dst_q, dir_q) : SEL_IDLE;
    pipe_last_in = enb_q & last_q;
    pipe_done_in = (state_q == ST_DRAIN) & zlen_q;
  end

  tb_sel_delay #(
    .RD_LAT(RD_LAT)
  ) u_sel_delay (
    .clk    (clk),
    .rst_n  (sys_rst_n),
    .sel_i  (pipe_sel_in),
    .last_i (pipe_last_in),
    .done_i (pipe_done_in),
    .sel_o  (TB_doutb_sel),
    .last_o (pipe_last_out)
  );

  assign cmd_ready = (state_q == ST_IDLE);
  assign TB_enb    = enb_q;
  assign TB_addrb  = addrb_q;
  assign busy      = busy_q;
  assign rd_done   = pipe_last_out;

endmodule

// File: tb/tb_tb_portb_rd_seq.sv
// tb/tb_tb_portb_rd_seq.sv - directed vector bench for tb_portb_rd_seq at RD_LAT 1, 2 and 4
module tb_tb_portb_rd_seq;

  logic       clk = 1'b0;
  logic       sys_rst_n;
  logic       cmd_valid;
  logic [9:0] cmd_base;
  logic [7:0] cmd_len;
  logic [9:0] cmd_stride;
  logic       cmd_dst;
  logic [1:0] cmd_dir;
  logic       rd_stall;

  logic [2:0]       enb_o, done_o, rdy_o, busy_o;
  logic [2:0][9:0]  addr_o;
  logic [2:0][2:0]  sel_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       vld;
    logic       stall;
    logic       enb;
    logic [9:0] addr;
    logic [2:0] sel;
    logic       done;
    logic       rdy;
  } vec_t;

  vec_t tab[$];

  always #5 clk = ~clk;

  tb_portb_rd_seq #(.TB_AW(10), .LEN_W(8), .RD_LAT(1)) u_lat1 (
    .clk(clk), .sys_rst_n(sys_rst_n), .cmd_valid(cmd_valid), .cmd_ready(rdy_o[0]),
    .cmd_base(cmd_base), .cmd_len(cmd_len), .cmd_stride(cmd_stride), .cmd_dst(cmd_dst),
    .cmd_dir(cmd_dir), .rd_stall(rd_stall), .TB_enb(enb_o[0]), .TB_addrb(addr_o[0]),
    .TB_doutb_sel(sel_o[0]), .busy(busy_o[0]), .rd_done(done_o[0]));

  tb_portb_rd_seq #(.TB_AW(10), .LEN_W(8), .RD_LAT(2)) u_lat2 (
    .clk(clk), .sys_rst_n(sys_rst_n), .cmd_valid(cmd_valid), .cmd_ready(rdy_o[1]),
    .cmd_base(cmd_base), .cmd_len(cmd_len), .cmd_stride(cmd_stride), .cmd_dst(cmd_dst),
    .cmd_dir(cmd_dir), .rd_stall(rd_stall), .TB_enb(enb_o[1]), .TB_addrb(addr_o[1]),
    .TB_doutb_sel(sel_o[1]), .busy(busy_o[1]), .rd_done(done_o[1]));

  tb_portb_rd_seq #(.TB_AW(10), .LEN_W(8), .RD_LAT(4)) u_lat4 (
    .clk(clk), .sys_rst_n(sys_rst_n), .cmd_valid(cmd_valid), .cmd_ready(rdy_o[2]),
    .cmd_base(cmd_base), .cmd_len(cmd_len), .cmd_stride(cmd_stride), .cmd_dst(cmd_dst),
    .cmd_dir(cmd_dir), .rd_stall(rd_stall), .TB_enb(enb_o[2]), .TB_addrb(addr_o[2]),
    .TB_doutb_sel(sel_o[2]), .busy(busy_o[2]), .rd_done(done_o[2]));

  function automatic vec_t r(input int vld, input int stall, input int enb, input int addr,
                             input int sel, input int done, input int rdy);
    vec_t x;
    x.vld   = 1'(vld);
    x.stall = 1'(stall);
    x.enb   = 1'(enb);
    x.addr  = 10'(addr);
    x.sel   = 3'(sel);
    x.done  = 1'(done);
    x.rdy   = 1'(rdy);
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_row(input string nm, input int inst, input int row, input vec_t e);
    chk($sformatf("%s row%0d enb", nm, row),   32'(enb_o[inst]),  32'(e.enb));
    chk($sformatf("%s row%0d addrb", nm, row), 32'(addr_o[inst]), 32'(e.addr));
    chk($sformatf("%s row%0d sel", nm, row),   32'(sel_o[inst]),  32'(e.sel));
    chk($sformatf("%s row%0d done", nm, row),  32'(done_o[inst]), 32'(e.done));
    chk($sformatf("%s row%0d ready", nm, row), 32'(rdy_o[inst]),  32'(e.rdy));
    chk($sformatf("%s row%0d busy", nm, row),  32'(busy_o[inst]), 32'(!e.rdy));
  endtask

  // Row i: vld/stall are present at clock edge i, expectations hold just after it
  task automatic run_table(input string nm, input int inst);
    foreach (tab[i]) begin
      cmd_valid = tab[i].vld;
      rd_stall  = tab[i].stall;
      @(posedge clk);
      #1;
      check_row(nm, inst, i, tab[i]);
    end
    tab.delete();
  endtask

  task automatic set_cmd(input int base, input int len, input int stride, input int dst, input int dir);
    cmd_base   = 10'(base);
    cmd_len    = 8'(len);
    cmd_stride = 10'(stride);
    cmd_dst    = 1'(dst);
    cmd_dir    = 2'(dir);
  endtask

  task automatic wait_idle();
    cmd_valid = 1'b0;
    rd_stall  = 1'b0;
    for (int n = 0; n < 64 && busy_o != 3'b000; n++) begin
      @(posedge clk);
      #1;
    end
    chk("wait_idle busy", 32'(busy_o), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    sys_rst_n = 1'b0;
    cmd_valid = 1'b0;
    rd_stall  = 1'b0;
    set_cmd(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset enb",   32'(enb_o),  32'd0);
    chk("reset addrb", 32'(addr_o), 32'd0);
    chk("reset sel",   32'(sel_o),  32'd0);
    chk("reset done",  32'(done_o), 32'd0);
    chk("reset busy",  32'(busy_o), 32'd0);
    chk("reset ready", 32'(rdy_o),  32'h7);
    sys_rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Plain 4-row read at RD_LAT=1
    set_cmd('h010, 4, 1, 0, 2'b01);
    tab.push_back(r(1, 0, 0, 'h000, 0, 0, 0));
    tab.push_back(r(0, 0, 1, 'h010, 0, 0, 0));
    tab.push_back(r(0, 0, 1, 'h011, 1, 0, 0));
    tab.push_back(r(0, 0, 1, 'h012, 1, 0, 0));
    tab.push_back(r(0, 0, 1, 'h013, 1, 0, 0));
    tab.push_back(r(0, 0, 0, 'h013, 1, 1, 0));
    tab.push_back(r(0, 0, 0, 'h013, 0, 0, 1));
    run_table("basic", 0);
    wait_idle();

    // Address wrap past the top of the row space, B_cache / NEG
    set_cmd('h3FE, 4, 1, 1, 2'b10);
    tab.push_back(r(1, 0, 0, 'h013, 0, 0, 0));
    tab.push_back(r(0, 0, 1, 'h3FE, 0, 0, 0));
    tab.push_back(r(0, 0, 1, 'h3FF, 6, 0, 0));
    tab.push_back(r(0, 0, 1, 'h000, 6, 0, 0));
    tab.push_back(r(0, 0, 1, 'h001, 6, 0, 0));
    tab.push_back(r(0, 0, 0, 'h001, 6, 1, 0));
    tab.push_back(r(0, 0, 0, 'h001, 0, 0, 1));
    run_table("wrap", 0);
    wait_idle();

    // Stall in the 2nd issue cycle at RD_LAT=2; stall during DRAIN is ignored
    set_cmd('h000, 3, 4, 0, 2'b01);
    tab.push_back(r(1, 0, 0, 'h001, 0, 0, 0));
    tab.push_back(r(0, 0, 1, 'h000, 0, 0, 0));
    tab.push_back(r(0, 1, 0, 'h000, 0, 0, 0));
    tab.push_back(r(0, 0, 1, 'h004, 1, 0, 0));
    tab.push_back(r(0, 0, 1, 'h008, 0, 0, 0));
    tab.push_back(r(0, 1, 0, 'h008, 1, 0, 0));
    tab.push_back(r(0, 1, 0, 'h008, 1, 1, 0));
    tab.push_back(r(0, 0, 0, 'h008, 0, 0, 1));
    run_table("stall", 1);
    wait_idle();

    // len=0 with cmd_valid held: done one cycle after accept, re-accept only in IDLE
    set_cmd('h155, 0, 1, 1, 2'b11);
    tab.push_back(r(1, 0, 0, 'h008, 0, 0, 0));
    tab.push_back(r(1, 0, 0, 'h008, 0, 1, 0));
    tab.push_back(r(1, 0, 0, 'h008, 0, 0, 1));
    tab.push_back(r(1, 0, 0, 'h008, 0, 0, 0));
    tab.push_back(r(0, 0, 0, 'h008, 0, 1, 0));
    tab.push_back(r(0, 0, 0, 'h008, 0, 0, 1));
    tab.push_back(r(0, 0, 0, 'h008, 0, 0, 1));
    run_table("zero_len", 2);
    wait_idle();

    // Asynchronous reset after 2 of 8 rows
    set_cmd('h020, 8, 1, 0, 2'b01);
    tab.push_back(r(1, 0, 0, 'h008, 0, 0, 0));
    tab.push_back(r(0, 0, 1, 'h020, 0, 0, 0));
    tab.push_back(r(0, 0, 1, 'h021, 1, 0, 0));
    run_table("pre_reset", 0);
    #3;
    sys_rst_n = 1'b0;
    #1;
    chk("async_rst enb",   32'(enb_o),  32'd0);
    chk("async_rst addrb", 32'(addr_o), 32'd0);
    chk("async_rst sel",   32'(sel_o),  32'd0);
    chk("async_rst done",  32'(done_o), 32'd0);
    chk("async_rst busy",  32'(busy_o), 32'd0);
    chk("async_rst ready", 32'(rdy_o),  32'h7);
    @(posedge clk);
    #1;
    sys_rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_rst%0d done", i), 32'(done_o), 32'd0);
      chk($sformatf("post_rst%0d enb", i),  32'(enb_o),  32'd0);
    end
    set_cmd('h040, 2, 3, 0, 2'b01);
    tab.push_back(r(1, 0, 0, 'h000, 0, 0, 0));
    tab.push_back(r(0, 0, 1, 'h040, 0, 0, 0));
    tab.push_back(r(0, 0, 1, 'h043, 1, 0, 0));
    tab.push_back(r(0, 0, 0, 'h043, 1, 1, 0));
    tab.push_back(r(0, 0, 0, 'h043, 0, 0, 1));
    run_table("after_reset", 0);
    wait_idle();

    // Back-to-back at RD_LAT=4: second command held valid, accepted after full drain
    set_cmd('h080, 2, 1, 1, 2'b01);
    tab.push_back(r(1, 0, 0, 'h043, 0, 0, 0));
    run_table("b2b_accept", 2);
    set_cmd('h200, 2, 'h10, 0, 2'b10);
    tab.push_back(r(1, 0, 1, 'h080, 0, 0, 0));
    tab.push_back(r(1, 0, 1, 'h081, 0, 0, 0));
    tab.push_back(r(1, 0, 0, 'h081, 0, 0, 0));
    tab.push_back(r(1, 0, 0, 'h081, 0, 0, 0));
    tab.push_back(r(1, 0, 0, 'h081, 5, 0, 0));
    tab.push_back(r(1, 0, 0, 'h081, 5, 1, 0));
    tab.push_back(r(1, 0, 0, 'h081, 0, 0, 1));
    tab.push_back(r(1, 0, 0, 'h081, 0, 0, 0));
    tab.push_back(r(0, 0, 1, 'h200, 0, 0, 0));
    tab.push_back(r(0, 0, 1, 'h210, 0, 0, 0));
    tab.push_back(r(0, 0, 0, 'h210, 0, 0, 0));
    tab.push_back(r(0, 0, 0, 'h210, 0, 0, 0));
    tab.push_back(r(0, 0, 0, 'h210, 2, 0, 0));
    tab.push_back(r(0, 0, 0, 'h210, 2, 1, 0));
    tab.push_back(r(0, 0, 0, 'h210, 0, 0, 1));
    run_table("b2b", 2);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tb_portb_rd_seq.md
Name: tb_portb_rd_seq

Overview:
- Read sequencer for port B of the TB buffer, directly upstream of the TB port-B data remap stage.
- Accepts one read command (base row, row count, stride, direction, destination B or B_cache) and issues TB_enb/TB_addrb row by row.
- Delays the 3-bit TB_doutb_sel code by the BRAM read latency, so each code reaches the remap stage in the same cycle as its TB_doutb word.
- Supports stall bubbles and pulses a done flag on the last row.

Parameters:
- TB_AW, 10, TB row address width.
- LEN_W, 8, width of the row-count field.
- RD_LAT, 1, TB port-B read latency in cycles (legal range 1..4).

Ports:
- clk  in  1  system clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at a rising edge.
- cmd_base  in  TB_AW  first row address.
- cmd_len  in  LEN_W  number of rows to read (0 = no-op).
- cmd_stride  in  TB_AW  address increment per row.
- cmd_dst  in  1  0 = B, 1 = B_cache (becomes sel[2]).
- cmd_dir  in  2  00 IDLE, 01 POS, 10 NEG, 11 NEW (becomes sel[1:0]).
- rd_stall  in  1  downstream hold; suppresses issue while high.
- TB_enb  out  1  TB port-B read enable.
- TB_addrb  out  TB_AW  TB port-B row address.
- TB_doutb_sel  out  3  {dst, dir}, aligned with TB_doutb.
- busy  out  1  high while not in IDLE.
- rd_done  out  1  one-cycle pulse.

Behaviour:
- Reset (asynchronous, sys_rst_n low):
  - state IDLE; all sel pipeline stages 000.
  - TB_enb 0, TB_addrb 0, TB_doutb_sel 000, rd_done 0, busy 0, cmd_ready 1 (after reset deasserts).
  - Reset mid-command aborts the command with no done pulse.
- Outputs: all are registered except cmd_ready, which equals (state == IDLE).
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - On accept, latch base/len/stride/dst/dir and clear the row counter k to 0.
  - len != 0 -> ISSUE.
  - len == 0 -> DRAIN with an empty pipeline; rd_done pulses on the next cycle, then back to IDLE, and TB_enb is never asserted.
- ISSUE:
  - Each cycle with rd_stall = 0: TB_enb = 1, TB_addrb = base + k*stride (mod 2^TB_AW, wraps silently), k increments.
  - Address is kept as a running sum (addr += stride); no multiplier.
  - Cycle with rd_stall = 1: TB_enb = 0, TB_addrb holds its value, k holds, and a 000 bubble enters the sel pipe.
  - After issuing row len-1 -> DRAIN.
- DRAIN:
  - TB_enb = 0; rd_stall is ignored, since data is already in flight.
  - Leaves for IDLE once the last valid sel code has been presented.
- Sel pipeline:
  - RD_LAT-stage shift register.
  - Stage-0 input = {dst, dir} in a cycle where TB_enb = 1, else 000.
  - TB_doutb_sel = last stage, so a code issued with TB_enb at cycle c appears at cycle c + RD_LAT.
  - 000 is the all-idle code for both destinations.
  - dir = 00 and dir = 11 are passed through unchanged; no special handling.
- rd_done: asserted in the same cycle TB_doutb_sel carries the last row's code. cmd_ready rises the following cycle.
- Timeline (accept at edge T0, no stall): TB_enb high in cycles T0+1 .. T0+len; sel valid in cycles T0+1+RD_LAT .. T0+len+RD_LAT.
- Command overlap: none. cmd_valid while busy is ignored (held off by cmd_ready = 0). A command held valid through busy is accepted on the first cycle back in IDLE.
- Simultaneous stall and last row: the last row is issued only when stall is low; DRAIN is not entered until it is issued.

Decomposition:
- Shared package tb_pkg:
  - DIR_IDLE/DIR_POS/DIR_NEG/DIR_NEW (2-bit).
  - TB_B/TB_B_cache (1-bit).
  - SEL_IDLE = 3'b000.
  - FSM state encoding.
- One sub-module: tb_sel_delay. A parameterized RD_LAT-deep, 3-bit shift register with async active-low reset, which also carries a 1-bit "last" flag used to generate rd_done.

Test Plan:
- Reset then base = 0x010, len = 4, stride = 1, dst = 0, dir = 01, RD_LAT = 1 -> TB_addrb 0x010..0x013 with TB_enb over 4 cycles; sel = 3'b001 one cycle later on each; rd_done with the 4th sel; cmd_ready high the next cycle.
- base = 0x3FE, len = 4, stride = 1, dst = 1, dir = 10 -> addresses 0x3FE, 0x3FF, 0x000, 0x001 (wrap); sel = 3'b110 for 4 cycles.
- len = 3, stride = 4, rd_stall high in the 2nd issue cycle, RD_LAT = 2 -> addrb 0x000, (hold), 0x004, 0x008; sel stream 001, 000, 001, 001 offset by 2 cycles; rd_done with the last 001.
- len = 0 accepted -> TB_enb never high, sel stays 000, rd_done one cycle after accept; cmd_valid held high during busy is accepted only after return to IDLE.
- Drive sys_rst_n low mid-ISSUE, after 2 of 8 rows -> all outputs 0 and cmd_ready 1 immediately (asynchronous, no clock edge needed), no rd_done; the next command runs from k = 0.
- Back-to-back commands with RD_LAT = 4 -> no sel codes from the first command overlap the second; the gap between commands is exactly the DRAIN cycles.
